// File: rtl/execute_mdu.sv
// Iterative RV64M multiply/divide unit beside the execute-stage ALU.
// Radix-2 shift-add multiply and restoring divide, one bit per clock.
module execute_mdu #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic            word,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_W = ~XLEN'(32'h7fff_ffff);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;

    logic [2*XLEN-1:0] acc, acc_nx, mcand, mcand_nx, prod;
    logic [XLEN-1:0]   mplier, mplier_nx, quo, rem, raw, fin;
    logic [XLEN:0]     shifted, trial;
    logic [CW-1:0]     cnt;
    logic [2:0]        op_q;
    logic              word_q, neg_q, rneg_q;

    logic              accept, go, step, last;
    logic              word_eff, sgn1, sgn2, a_neg, b_neg, special;
    logic [XLEN-1:0]   a_ext, b_ext, mag_a, mag_b, spec_raw;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    assign in_ready  = (state == IDLE) && !reset;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;
    assign go        = accept && !flush;
    assign step      = (state == RUN) && !flush;
    assign last      = (cnt == CW'(1));

    // Operand preparation and special-case detection on the live inputs.
    always_comb begin
        word_eff = (XLEN == 64) && word && (op == 3'd0 || op[2]);
        sgn1     = op inside {3'd1, 3'd2, 3'd4, 3'd6};
        sgn2     = op inside {3'd1, 3'd4, 3'd6};
        a_ext    = src1;
        b_ext    = src2;
        if (word_eff) begin
            if (op == 3'd5 || op == 3'd7) begin
                a_ext = XLEN'(src1[31:0]);
                b_ext = XLEN'(src2[31:0]);
            end else begin
                a_ext = sext32(src1[31:0]);
                b_ext = sext32(src2[31:0]);
            end
        end
        a_neg    = sgn1 && a_ext[XLEN-1];
        b_neg    = sgn2 && b_ext[XLEN-1];
        mag_a    = a_neg ? -a_ext : a_ext;
        mag_b    = b_neg ? -b_ext : b_ext;
        special  = 1'b0;
        spec_raw = '0;
        if (op[2] && b_ext == '0) begin
            special  = 1'b1;
            spec_raw = op[1] ? a_ext : '1;
        end else if (op[2] && !op[0] && b_ext == '1 &&
                     a_ext == (word_eff ? MIN_W : MIN_X)) begin
            special  = 1'b1;
            spec_raw = op[1] ? '0 : a_ext;
        end
        if (word_eff) spec_raw = sext32(spec_raw[31:0]);
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = special ? DONE : RUN;
            RUN:     if (last) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    // One iteration: shift-add for multiply, trial subtract for divide.
    always_comb begin
        acc_nx    = acc;
        mcand_nx  = mcand;
        mplier_nx = mplier;
        shifted   = {acc[XLEN-1:0], mplier[XLEN-1]};
        trial     = shifted - {1'b0, mcand[XLEN-1:0]};
        if (op_q[2]) begin
            acc_nx    = {{(XLEN-1){1'b0}}, trial[XLEN] ? shifted : trial};
            mplier_nx = {mplier[XLEN-2:0], ~trial[XLEN]};
        end else begin
            if (mplier[0]) acc_nx = acc + mcand;
            mcand_nx  = mcand << 1;
            mplier_nx = mplier >> 1;
        end
    end

    always_comb begin
        prod = neg_q ? -acc_nx : acc_nx;
        quo  = neg_q ? -mplier_nx : mplier_nx;
        rem  = rneg_q ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0];
        raw  = '0;
        unique case (op_q)
            3'd0:             raw = prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3: raw = prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:       raw = quo;
            3'd6, 3'd7:       raw = rem;
        endcase
        fin = word_q ? sext32(raw[31:0]) : raw;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            result <= '0;
            op_q   <= '0;
            word_q <= 1'b0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
        end else if (go) begin
            op_q   <= op;
            word_q <= word_eff;
            neg_q  <= a_neg ^ b_neg;
            rneg_q <= a_neg;
            acc    <= '0;
            mcand  <= {{XLEN{1'b0}}, op[2] ? mag_b : mag_a};
            // Word dividends start in the top half so 32 shifts consume them.
            if (op[2])
                mplier <= word_eff ? (mag_a << (XLEN/2)) : mag_a;
            else
                mplier <= mag_b;
            if (special) begin
                cnt    <= '0;
                result <= spec_raw;
            end else begin
                cnt    <= word_eff ? CW'(32) : CW'(XLEN);
            end
        end else if (step) begin
            acc    <= acc_nx;
            mcand  <= mcand_nx;
            mplier <= mplier_nx;
            cnt    <= cnt - CW'(1);
            if (last) result <= fin;
        end
    end
endmodule

// File: tb/tb_execute_mdu.sv
// Bench for execute_mdu: vector table, hand-written sequences and
// random ops checked against an arithmetic reference model.
module tb_execute_mdu;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op_i = 3'd0;
    logic        word_i = 1'b0;
    logic [63:0] src1 = '0;
    logic [63:0] src2 = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] result;
    logic        busy;

    int n_checks = 0;
    int n_fail = 0;

    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES = 64'hffff_ffff_ffff_ffff;

    typedef struct {
        logic [2:0]  op;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    execute_mdu #(.XLEN(64)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .op(op_i),
        .word(word_i),
        .src1(src1),
        .src2(src2),
        .flush(flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result(result),
        .busy(busy)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Reference model: RISC-V M semantics in plain arithmetic.
    function automatic logic [63:0] model(input logic [2:0] o, input logic w,
                                          input logic [63:0] a,
                                          input logic [63:0] b);
        logic [127:0]       p;
        logic [31:0]        r32;
        logic [63:0]        r;
        logic signed [63:0] sa, sb;
        logic signed [31:0] sa32, sb32;
        logic               ovf, ovf32;
        sa    = a;
        sb    = b;
        sa32  = a[31:0];
        sb32  = b[31:0];
        ovf   = (a == MIN64) && (b == ONES);
        ovf32 = (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hffff_ffff);
        r32   = '0;
        r     = '0;
        p     = '0;
        if (w && (o == 3'd0 || o[2])) begin
            case (o)
                3'd0: r32 = a[31:0] * b[31:0];
                3'd4: begin
                    if (b[31:0] == 0) r32 = '1;
                    else if (ovf32) r32 = a[31:0];
                    else r32 = sa32 / sb32;
                end
                3'd5: begin
                    if (b[31:0] == 0) r32 = '1;
                    else r32 = a[31:0] / b[31:0];
                end
                3'd6: begin
                    if (b[31:0] == 0) r32 = a[31:0];
                    else if (ovf32) r32 = '0;
                    else r32 = sa32 % sb32;
                end
                default: begin
                    if (b[31:0] == 0) r32 = a[31:0];
                    else r32 = a[31:0] % b[31:0];
                end
            endcase
            return {{32{r32[31]}}, r32};
        end
        case (o)
            3'd0: r = a * b;
            3'd1: begin
                p = {{64{a[63]}}, a} * {{64{b[63]}}, b};
                r = p[127:64];
            end
            3'd2: begin
                p = {{64{a[63]}}, a} * {64'b0, b};
                r = p[127:64];
            end
            3'd3: begin
                p = {64'b0, a} * {64'b0, b};
                r = p[127:64];
            end
            3'd4: begin
                if (b == 0) r = ONES;
                else if (ovf) r = a;
                else r = sa / sb;
            end
            3'd5: r = (b == 0) ? ONES : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (ovf) r = '0;
                else r = sa % sb;
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int model_lat(input logic [2:0] o, input logic w,
                                     input logic [63:0] a,
                                     input logic [63:0] b);
        logic we;
        we = w && (o == 3'd0 || o[2]);
        if (o[2]) begin
            if (we) begin
                if (b[31:0] == 0) return 1;
                if (!o[0] && a[31:0] == 32'h8000_0000 &&
                    b[31:0] == 32'hffff_ffff) return 1;
            end else begin
                if (b == 0) return 1;
                if (!o[0] && a == MIN64 && b == ONES) return 1;
            end
        end
        return we ? 33 : 65;
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return ONES;
            2: return MIN64;
            3: return {32'($urandom), 32'h8000_0000};
            4: return {32'($urandom), 32'hffff_ffff};
            5: return {32'($urandom), 32'h0};
            6: return 64'($urandom_range(0, 20));
            default: return {32'($urandom), 32'($urandom)};
        endcase
    endfunction

    task automatic add_vec(input logic [2:0] o, input logic w,
                           input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] exp, input int lat);
        vec_t v;
        v.op  = o;
        v.w   = w;
        v.a   = a;
        v.b   = b;
        v.exp = exp;
        v.lat = lat;
        vecs.push_back(v);
    endtask

    // Waits for in_ready, accepts one op, then scrambles the inputs.
    task automatic issue(input logic [2:0] o, input logic w,
                         input logic [63:0] a, input logic [63:0] b,
                         output bit ok);
        int k;
        k  = 0;
        ok = 1'b0;
        while (!in_ready && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            timeout("issue");
            return;
        end
        op_i     = o;
        word_i   = w;
        src1     = a;
        src2     = b;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        op_i     = 3'($urandom);
        word_i   = 1'($urandom);
        src1     = {32'($urandom), 32'($urandom)};
        src2     = {32'($urandom), 32'($urandom)};
        ok       = 1'b1;
    endtask

    task automatic wait_result(output logic [63:0] res, output int lat,
                               output bit busy_ok, output bit ok);
        int k;
        k       = 1;
        busy_ok = 1'b1;
        ok      = 1'b0;
        res     = '0;
        lat     = -1;
        while (!out_valid && k < 300) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
            k++;
        end
        if (!out_valid) begin
            timeout("result");
            return;
        end
        if (!busy) busy_ok = 1'b0;
        res = result;
        lat = k;
        ok  = 1'b1;
    endtask

    task automatic run_vec(input string name, input logic [2:0] o,
                           input logic w, input logic [63:0] a,
                           input logic [63:0] b, input logic [63:0] exp,
                           input int lat_exp);
        logic [63:0] res;
        int          lat;
        bit          ok, bok;
        out_ready = 1'b1;
        issue(o, w, a, b, ok);
        if (!ok) return;
        wait_result(res, lat, bok, ok);
        if (!ok) return;
        check({name, "_result"}, res, exp);
        check({name, "_latency"}, 64'(lat), 64'(lat_exp));
        check({name, "_busy"}, 64'(bok), 64'd1);
    endtask

    initial begin
        logic [63:0] res, ra, rb;
        int          lat;
        bit          ok, bok, seen;
        logic [2:0]  ro;
        logic        rw;

        add_vec(3'd0, 0, 64'd7, 64'hffff_ffff_ffff_fff9,
                64'hffff_ffff_ffff_ffcf, 65);
        add_vec(3'd3, 0, ONES, 64'd2, 64'd1, 65);
        add_vec(3'd1, 0, ONES, ONES, 64'd0, 65);
        add_vec(3'd2, 0, ONES, 64'd2, ONES, 65);
        add_vec(3'd4, 0, 64'd5, 64'd0, ONES, 1);
        add_vec(3'd7, 0, 64'd5, 64'd0, 64'd5, 1);
        add_vec(3'd4, 0, MIN64, ONES, MIN64, 1);
        add_vec(3'd6, 0, MIN64, ONES, 64'd0, 1);
        add_vec(3'd4, 0, 64'hffff_ffff_ffff_fff9, 64'd2,
                64'hffff_ffff_ffff_fffd, 65);
        add_vec(3'd6, 0, 64'hffff_ffff_ffff_fff9, 64'd2, ONES, 65);
        add_vec(3'd0, 1, 64'h7fff_ffff, 64'd2,
                64'hffff_ffff_ffff_fffe, 33);
        add_vec(3'd5, 1, 64'h1234_5678_ffff_fffe, 64'd2,
                64'h0000_0000_7fff_ffff, 33);
        add_vec(3'd6, 1, 64'hffff_fff9, 64'd2, ONES, 33);
        add_vec(3'd4, 1, 64'h8000_0000, ONES,
                64'hffff_ffff_8000_0000, 1);
        add_vec(3'd1, 1, ONES, ONES, 64'd0, 65);
        add_vec(3'd7, 1, 64'h0000_0000_8000_0001, 64'hffff_ffff_0000_0000,
                64'hffff_ffff_8000_0001, 1);

        repeat (3) @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_result", result, 64'd0);
        reset = 1'b0;
        #1;
        check("release_in_ready", 64'(in_ready), 64'd1);

        foreach (vecs[i])
            run_vec($sformatf("vec%0d", i), vecs[i].op, vecs[i].w,
                    vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

        // Backpressure: result held in DONE until the consumer takes it.
        issue(3'd5, 0, 64'd100, 64'd7, ok);
        out_ready = 1'b0;
        wait_result(res, lat, bok, ok);
        check("bp_result", res, 64'd14);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_hold", result, 64'd14);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 64'(out_valid), 64'd0);
        check("bp_release_ready", 64'(in_ready), 64'd1);

        // Flush at iteration 20 of a DIV.
        issue(3'd4, 0, 64'd1000, 64'd3, ok);
        repeat (19) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        seen = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("flush_no_valid", 64'(seen), 64'd0);

        // Flush in the accept cycle cancels the accept.
        op_i     = 3'd0;
        word_i   = 1'b0;
        src1     = 64'd3;
        src2     = 64'd5;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush_accept_busy", 64'(busy), 64'd0);
        seen = 1'b0;
        repeat (70) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("flush_accept_no_valid", 64'(seen), 64'd0);
        run_vec("after_flush", 3'd0, 0, 64'd6, 64'd7, 64'd42, 65);

        for (int i = 0; i < 60; i++) begin
            ro = 3'($urandom);
            rw = 1'($urandom);
            ra = pick();
            rb = pick();
            run_vec($sformatf("rnd%0d_op%0d_w%0d", i, ro, rw), ro, rw,
                    ra, rb, model(ro, rw, ra, rb), model_lat(ro, rw, ra, rb));
        end

        // Reset in the middle of a MUL.
        issue(3'd0, 0, 64'd5, 64'd6, ok);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_out_valid", 64'(out_valid), 64'd0);
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_result", result, 64'd0);
        check("midreset_in_ready", 64'(in_ready), 64'd0);
        reset = 1'b0;
        #1;
        check("midreset_release", 64'(in_ready), 64'd1);
        run_vec("post_reset_mul", 3'd0, 0, 64'd3, 64'd4, 64'd12, 65);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/execute_mdu.md
# execute_mdu

Iterative multi-cycle multiply/divide unit for the execute stage. Implements the RV64M operations MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and their 32-bit word forms, and is parametrised in datapath width. It sits beside the single-cycle ALU. The execute stage dispatches M-extension instructions to it over a valid/ready handshake and stalls the pipeline until the result is consumed. It supports a pipeline flush that abandons an operation in flight.

## Interface
Parameters:
- XLEN, 64: datapath width. Must be 32 or 64. Word mode is meaningful only when XLEN=64.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- op  in  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- word  in  1  word (*W) operation. Ignored for op 1–3.
- src1, src2  in  XLEN  operands rs1, rs2
- flush  in  1  discard any operation in progress
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  XLEN  operation result
- busy  out  1  state ≠ IDLE

## Operation
- States and transitions:
  - IDLE → RUN on accept, where accept = in_valid && in_ready.
  - IDLE → DONE on accept when the operation is a special-case division.
  - RUN → DONE after N iterations.
  - DONE → IDLE on out_valid && out_ready.
- Output decode:
  - in_ready = (state==IDLE) && !reset.
  - out_valid = (state==DONE).
- Operands and inputs are latched at accept. Input changes after accept have no effect.
- Iteration count: N = 32 if word, else XLEN. An iteration counter counts down from N.
- Word-mode operand preparation: operands are the low 32 bits.
  - Sign-extended for signed ops (MUL, DIV, REM).
  - Zero-extended for DIVU and REMU.
- Word-mode result: low 32 bits of the internal result, sign-extended to XLEN. This applies to every word op, including DIVU and REMU.
- Multiply:
  - Radix-2 shift-add on the operand magnitudes, producing a 2N-bit product.
  - The product is negated if the effective operand signs differ. MULH treats both operands as signed. MULHSU treats src1 as signed and src2 as unsigned. MUL and MULHU treat both as unsigned; for MUL the low half is sign-agnostic.
  - MUL returns the low N bits. MULH* return the high XLEN bits.
- Divide:
  - Restoring division, one quotient bit per iteration, on the magnitudes.
  - Quotient is negative iff the signs differ (signed ops only).
  - Remainder takes the sign of the dividend.
- Special cases, resolved at accept with no RUN phase:
  - Divide by zero: quotient = all ones; remainder = dividend (after word extension).
  - Signed overflow (dividend = most-negative value of the effective width, divisor = −1): quotient = dividend; remainder = 0.
- Result holding: `result` is registered and held stable while in DONE, regardless of out_ready.
- Priority:
  - reset > flush > handshakes.
  - flush in any state sends the unit to IDLE on the next edge. out_valid is low from that edge onward and the discarded result is never presented.
  - flush in the same cycle as accept cancels that accept.

## Timing
- Reset values: state IDLE, out_valid 0, busy 0, result 0, counter 0. in_ready is 0 while reset is asserted and 1 in the first cycle after reset is released.
- Regular operation: accept on edge E. out_valid is first high in the cycle after edge E+N, i.e. N+1 cycles after the accept cycle.
  - XLEN=64: 65 cycles for a normal op, 33 cycles for a word op.
- Special-case divide: out_valid is high in the cycle after the accept edge, i.e. 1-cycle latency.
- Throughput:
  - After the result handshake, in_ready rises in the next cycle. There is no same-cycle re-accept.
  - Maximum throughput is one op per N+2 cycles.
- Reset asserted mid-operation aborts it. The post-reset state is identical to that after power-on reset.

## Test plan
- MUL, src1=7, src2=0xFFFF_FFFF_FFFF_FFF9 (−7) → result 0xFFFF_FFFF_FFFF_FFCF (−49). out_valid asserts exactly 65 cycles after the accept cycle. busy is high throughout.
- MULHU with src1=0xFFFF_FFFF_FFFF_FFFF, src2=2 → 1. MULH with −1 × −1 → 0. MULHSU with src1=−1, src2=2 → 0xFFFF_FFFF_FFFF_FFFF.
- Division corner cases:
  - DIV 5/0 → 0xFFFF_FFFF_FFFF_FFFF. REMU 5/0 → 5. Both with latency 1.
  - DIV 0x8000_0000_0000_0000 / −1 → 0x8000_0000_0000_0000. REM of the same operands → 0.
  - DIV −7/2 → −3. REM −7/2 → −1.
- Word ops:
  - MULW 0x7FFF_FFFF × 2 → 0xFFFF_FFFF_FFFF_FFFE, latency 33.
  - DIVUW with src1=0x1234_5678_FFFF_FFFE, src2=2 → 0x0000_0000_7FFF_FFFF. The upper operand bits are ignored.
  - REMW 0xFFFF_FFF9 % 2 → 0xFFFF_FFFF_FFFF_FFFF.
  - DIVW 0x8000_0000 / −1 → 0xFFFF_FFFF_8000_0000.
- Backpressure: hold out_ready=0 for 10 cycles in DONE. result and out_valid stay stable and in_ready stays 0. After the handshake, in_ready is 1 on the next cycle.
- Flush and reset:
  - Assert flush at iteration 20 of a DIV. The next cycle shows IDLE and in_ready=1, and out_valid never rises.
  - Assert reset mid-MUL. All outputs take their reset values and a subsequent MUL 3×4 returns 12.
